// File: rtl/alu_pkg.sv
// Shared opcodes, state encoding and default widths for the execute-stage ALU.
package alu_pkg;

    localparam int DEFAULT_XLEN    = 32;
    localparam int DEFAULT_SHAMT_W = 5;

    // Opcode is {funct7[5], funct3}
    localparam logic [3:0] ALU_OP_ADD  = 4'b0000;
    localparam logic [3:0] ALU_OP_SUB  = 4'b1000;
    localparam logic [3:0] ALU_OP_SLL  = 4'b0001;
    localparam logic [3:0] ALU_OP_SLT  = 4'b0010;
    localparam logic [3:0] ALU_OP_SLTU = 4'b0011;
    localparam logic [3:0] ALU_OP_XOR  = 4'b0100;
    localparam logic [3:0] ALU_OP_SRL  = 4'b0101;
    localparam logic [3:0] ALU_OP_SRA  = 4'b1101;
    localparam logic [3:0] ALU_OP_OR   = 4'b0110;
    localparam logic [3:0] ALU_OP_AND  = 4'b0111;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } alu_state_e;

    function automatic logic op_is_shift(input logic [3:0] op);
        return (op == ALU_OP_SLL) || (op == ALU_OP_SRL) || (op == ALU_OP_SRA);
    endfunction

endpackage

// File: rtl/alu_serial_shifter.sv
// Serial shifter: moves the working register one bit per cycle while the
// down-counter is non-zero; data_o is the value the next step produces.
module alu_serial_shifter
    import alu_pkg::*;
#(
    parameter int XLEN    = DEFAULT_XLEN,
    parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               load_i,
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic               left_i,
    input  logic               arith_i,
    output logic               busy_o,
    output logic               done_o,
    output logic [XLEN-1:0]    data_o
);

    logic [XLEN-1:0]    work_q, work_d, step;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    logic               left_q, left_d;
    logic               arith_q, arith_d;

    always_comb begin
        if (left_q) begin
            step = {work_q[XLEN-2:0], 1'b0};
        end else begin
            step = {arith_q & work_q[XLEN-1], work_q[XLEN-1:1]};
        end
    end

    always_comb begin
        work_d  = work_q;
        cnt_d   = cnt_q;
        left_d  = left_q;
        arith_d = arith_q;
        if (load_i) begin
            work_d  = data_i;
            cnt_d   = shamt_i;
            left_d  = left_i;
            arith_d = arith_i;
        end else if (cnt_q != '0) begin
            work_d = step;
            cnt_d  = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            work_q  <= '0;
            cnt_q   <= '0;
            left_q  <= 1'b0;
            arith_q <= 1'b0;
        end else begin
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            left_q  <= left_d;
            arith_q <= arith_d;
        end
    end

    assign busy_o = (cnt_q != '0);
    assign done_o = (cnt_q == SHAMT_W'(1));
    assign data_o = step;

endmodule

// File: rtl/alu_exec.sv
// Execute-stage ALU with a one-deep valid/ready output register.
// Define ALU_EXEC_FAST_SHIFT_EN to replace the serial shifter with a barrel shifter.
module alu_exec
    import alu_pkg::*;
#(
    parameter int XLEN    = DEFAULT_XLEN,
    parameter int SHAMT_W = DEFAULT_SHAMT_W
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [3:0]      alu_op,
    input  logic [XLEN-1:0] rda,
    input  logic [XLEN-1:0] rdx,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero
);

    logic [XLEN-1:0]    result_q, result_d, quick;
    logic               zero_q, zero_d;
    logic               out_valid_q, out_valid_d;
    logic               accept, load_result;
    logic [SHAMT_W-1:0] shamt;

    assign shamt = rdx[SHAMT_W-1:0];

    // Single-cycle result; serial builds only need shamt==0 here, which is rda
    always_comb begin
        quick = '0;
        case (alu_op)
            ALU_OP_ADD:  quick = rda + rdx;
            ALU_OP_SUB:  quick = rda - rdx;
            ALU_OP_SLT:  quick = {{(XLEN-1){1'b0}}, ($signed(rda) < $signed(rdx))};
            ALU_OP_SLTU: quick = {{(XLEN-1){1'b0}}, (rda < rdx)};
            ALU_OP_XOR:  quick = rda ^ rdx;
            ALU_OP_OR:   quick = rda | rdx;
            ALU_OP_AND:  quick = rda & rdx;
`ifdef ALU_EXEC_FAST_SHIFT_EN
            ALU_OP_SLL:  quick = rda << shamt;
            ALU_OP_SRL:  quick = rda >> shamt;
            ALU_OP_SRA:  quick = XLEN'($signed(rda) >>> shamt);
`else
            ALU_OP_SLL:  quick = rda;
            ALU_OP_SRL:  quick = rda;
            ALU_OP_SRA:  quick = rda;
`endif
            default:     quick = '0;
        endcase
    end

`ifdef ALU_EXEC_FAST_SHIFT_EN
    assign in_ready    = reset && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign load_result = accept;
    assign result_d    = load_result ? quick : result_q;
`else
    alu_state_e      state_q, state_d;
    logic            start_shift, shift_done;
    logic            shf_busy, shf_done;
    logic [XLEN-1:0] shf_data;

    assign in_ready    = reset && (state_q == IDLE) && (!out_valid_q || out_ready);
    assign accept      = in_valid && in_ready;
    assign start_shift = accept && op_is_shift(alu_op) && (shamt != '0);
    assign shift_done  = (state_q == SHIFT) && shf_busy && shf_done;
    assign load_result = (accept && !start_shift) || shift_done;

    always_comb begin
        result_d = result_q;
        if (shift_done) begin
            result_d = shf_data;
        end else if (load_result) begin
            result_d = quick;
        end
    end

    alu_serial_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk_i   (clk),
        .rst_ni  (reset),
        .load_i  (start_shift),
        .data_i  (rda),
        .shamt_i (shamt),
        .left_i  (alu_op == ALU_OP_SLL),
        .arith_i (alu_op == ALU_OP_SRA),
        .busy_o  (shf_busy),
        .done_o  (shf_done),
        .data_o  (shf_data)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_shift) state_d = SHIFT;
            SHIFT:   if (shift_done)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end
`endif

    // A newly loaded result keeps out_valid high even when the old one drains
    always_comb begin
        out_valid_d = out_valid_q;
        zero_d      = zero_q;
        if (load_result) begin
            out_valid_d = 1'b1;
            zero_d      = (result_d == '0);
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            result_q    <= '0;
            zero_q      <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            result_q    <= result_d;
            zero_q      <= zero_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign result    = result_q;
    assign zero      = zero_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_alu_exec.sv
// Directed testbench for alu_exec with a cycle-level reference model.
// Honours ALU_EXEC_FAST_SHIFT_EN for expected shift latency.
module tb_alu_exec;
    import alu_pkg::*;

`ifdef ALU_EXEC_FAST_SHIFT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_op = 4'h0;
    logic [31:0] rda = '0;
    logic [31:0] rdx = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] result;
    logic        zero;

    int checks = 0;
    int errors = 0;

    alu_exec #(.XLEN(32), .SHAMT_W(5)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .alu_op    (alu_op),
        .rda       (rda),
        .rdx       (rdx),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    // Reference arithmetic taken straight from the opcode table
    function automatic logic [31:0] modelResult(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            ALU_OP_ADD:  return a + b;
            ALU_OP_SUB:  return a - b;
            ALU_OP_SLL:  return a << sh;
            ALU_OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_OP_SLTU: return (a < b) ? 32'd1 : 32'd0;
            ALU_OP_XOR:  return a ^ b;
            ALU_OP_SRL:  return a >> sh;
            ALU_OP_SRA:  return 32'($signed(a) >>> sh);
            ALU_OP_OR:   return a | b;
            ALU_OP_AND:  return a & b;
            default:     return 32'd0;
        endcase
    endfunction

    function automatic int modelLatency(input logic [3:0] op, input logic [31:0] b);
        if (FAST) return 1;
        if ((op == ALU_OP_SLL || op == ALU_OP_SRL || op == ALU_OP_SRA) && b[4:0] != 5'd0)
            return int'(b[4:0]) + 1;
        return 1;
    endfunction

    // Model: one op in flight, result appears latency cycles after acceptance
    bit          mLive = 1'b0;
    bit          mValid = 1'b0;
    bit          mAcc;
    int          mWait = 0;
    int          mLat;
    logic [31:0] mResult = '0;
    logic [31:0] mPend = '0;

    always @(posedge clk) begin
        if (!reset) begin
            mLive  = 1'b1;
            mValid = 1'b0;
            mWait  = 0;
        end else if (mLive) begin
            mAcc = in_valid && (mWait == 0) && (!mValid || out_ready);
            if (mValid && out_ready) mValid = 1'b0;
            if (mWait > 0) begin
                mWait--;
                if (mWait == 0) begin
                    mValid  = 1'b1;
                    mResult = mPend;
                end
            end
            if (mAcc) begin
                mLat = modelLatency(alu_op, rdx);
                if (mLat == 1) begin
                    mValid  = 1'b1;
                    mResult = modelResult(alu_op, rda, rdx);
                end else begin
                    mWait = mLat - 1;
                    mPend = modelResult(alu_op, rda, rdx);
                end
            end
        end
    end

    // Per-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (mLive) begin
            checks++;
            if (out_valid !== mValid) begin
                errors++;
                $display("[TB] FAIL cmp_out_valid t=%0t: got %b expected %b", $time, out_valid, mValid);
            end
            checks++;
            if (in_ready !== (reset && mWait == 0 && (!mValid || out_ready))) begin
                errors++;
                $display("[TB] FAIL cmp_in_ready t=%0t: got %b expected %b", $time, in_ready,
                         reset && mWait == 0 && (!mValid || out_ready));
            end
            if (mValid) begin
                checks++;
                if (result !== mResult || zero !== (mResult == 32'd0)) begin
                    errors++;
                    $display("[TB] FAIL cmp_result t=%0t: got %h/%b expected %h/%b", $time, result, zero,
                             mResult, (mResult == 32'd0));
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Offer an op and return 1 time unit after the edge that accepts it
    task automatic applyStimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        alu_op   = op;
        rda      = a;
        rdx      = b;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkOutput("accept_timeout", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rda      = ~a;
        rdx      = ~b;
        alu_op   = ALU_OP_AND;
    endtask

    task automatic runOp(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] expRes, input int expLat);
        int lat;
        int readyWhileBusy;
        bit got;
        lat = 0;
        readyWhileBusy = 0;
        got = 1'b0;
        applyStimulus(op, a, b);
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            lat++;
            if (out_valid) got = 1'b1;
            else if (in_ready) readyWhileBusy++;
        end
        checkOutput({name, "_valid"}, {31'd0, got}, 32'd1);
        checkOutput({name, "_result"}, result, expRes);
        checkOutput({name, "_zero"}, {31'd0, zero}, {31'd0, (expRes == 32'd0)});
        checkOutput({name, "_latency"}, 32'(lat), 32'(expLat));
        checkOutput({name, "_busy_ready"}, 32'(readyWhileBusy), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int seen;
        logic [31:0] expX [8];

        out_ready = 1'b1;
        reset     = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("rst_result", result, 32'd0);
        checkOutput("rst_zero", {31'd0, zero}, 32'd1);
        checkOutput("rst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] reset during a long shift");
        applyStimulus(ALU_OP_SLL, 32'd1, 32'd20);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        @(negedge clk);
        checkOutput("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("midrst_result", result, 32'd0);
        checkOutput("midrst_zero", {31'd0, zero}, 32'd1);
        checkOutput("midrst_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        checkOutput("postrst_in_ready", {31'd0, in_ready}, 32'd1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        checkOutput("postrst_stale", 32'(seen), 32'd0);
        @(posedge clk);
        #1;

        $display("[TB] arithmetic and logic");
        runOp("add_ovf", ALU_OP_ADD, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1);
        runOp("sub_zero", ALU_OP_SUB, 32'd5, 32'd5, 32'h0, 1);
        runOp("slt", ALU_OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'h1, 1);
        runOp("sltu", ALU_OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'h0, 1);
        runOp("or", ALU_OP_OR, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF, 1);
        runOp("unk_1111", 4'b1111, 32'h0000_FFFF, 32'h0000_FFFF, 32'h0, 1);
        runOp("unk_1001", 4'b1001, 32'h0000_0003, 32'h0000_0002, 32'h0, 1);

        $display("[TB] shifts");
        runOp("sra31", ALU_OP_SRA, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, FAST ? 1 : 32);
        runOp("srl31", ALU_OP_SRL, 32'h8000_0000, 32'd31, 32'h0000_0001, FAST ? 1 : 32);
        runOp("sll0", ALU_OP_SLL, 32'h1, 32'd0, 32'h1, 1);
        runOp("sll_0x25", ALU_OP_SLL, 32'h1, 32'h25, 32'h20, FAST ? 1 : 6);
        runOp("sra_pos", ALU_OP_SRA, 32'h4000_0000, 32'd2, 32'h1000_0000, FAST ? 1 : 3);

        $display("[TB] backpressure");
        out_ready = 1'b0;
        applyStimulus(ALU_OP_AND, 32'h0000_F0F0, 32'h0000_0FF0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checkOutput("bp_result", result, 32'h0000_00F0);
            checkOutput("bp_valid", {31'd0, out_valid}, 32'd1);
            checkOutput("bp_in_ready", {31'd0, in_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        in_valid  = 1'b1;
        alu_op    = ALU_OP_ADD;
        rda       = 32'd2;
        rdx       = 32'd3;
        @(negedge clk);
        checkOutput("bp_release_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("bp_next_result", result, 32'd5);
        checkOutput("bp_next_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1;

        $display("[TB] streaming XOR");
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            alu_op   = ALU_OP_XOR;
            rda      = 32'hA5A5_0000 + 32'(i);
            rdx      = 32'h0000_5A5A << i;
            expX[i]  = (32'hA5A5_0000 + 32'(i)) ^ (32'h0000_5A5A << i);
            @(negedge clk);
            checkOutput("stream_in_ready", {31'd0, in_ready}, 32'd1);
            if (i > 0) begin
                checkOutput("stream_valid", {31'd0, out_valid}, 32'd1);
                checkOutput("stream_result", result, expX[i-1]);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        checkOutput("stream_last_valid", {31'd0, out_valid}, 32'd1);
        checkOutput("stream_last_result", result, expX[7]);
        @(posedge clk);
        #1;
        @(negedge clk);
        checkOutput("drain_valid", {31'd0, out_valid}, 32'd0);

        repeat (3) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
